mem_arbiter: RTL

- Arbitrates the single byte-wide unified RAM port between instruction fetch (IF) and the MEM stage.
- Serialises 1/2/4-byte little-endian accesses into byte transactions.
- Returns assembled data plus a one-cycle done pulse to the winning requester.
- Drives mem_stall, which holds the MEM/WB pipeline register and upstream stages while a MEM access is outstanding.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the unified RAM port: MEM stage has priority over fetch,
// multi-byte little-endian accesses are split into consecutive byte transactions.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;        // 1 = MEM stage, 0 = fetch
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic              grant_mem, grant_if, if_abort;
    logic [2:0]        mem_n;
    logic [ADDR_W-1:0] addr_k;
    logic [1:0]        lane;
    logic [7:0]        wbyte;
    logic [DATA_W-1:0] rbuf_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    always_comb begin
        grant_mem = rdy & mem_req;
        grant_if  = rdy & if_req & ~if_flush & ~mem_req;
        if_abort  = ~owner_q & if_flush;
        case (mem_len)
            2'd0:    mem_n = 3'd1;
            2'd1:    mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
        // cnt_q is the index k of the edge about to happen; capture lane is k-2
        addr_k = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
        lane   = cnt_q[1:0] - 2'd2;
        wbyte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        rbuf_next = rbuf_q;
        rbuf_next[{lane, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_mem)
                    state_d = mem_we ? WRITE : READ;
                else if (grant_if)
                    state_d = READ;
            end
            READ: begin
                if (if_abort)
                    state_d = IDLE;
                else if (cnt_q == n_q + 3'd1)
                    state_d = DONE;
            end
            WRITE: begin
                if (cnt_q == n_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        case (state_q)
            IDLE: begin
                ram_wr_d = 1'b0;
                if (grant_mem) begin
                    owner_d    = 1'b1;
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    n_d        = mem_n;
                    cnt_d      = 3'd1;
                    rbuf_d     = '0;
                    ram_addr_d = mem_addr;
                    ram_wr_d   = mem_we;
                    if (mem_we)
                        ram_dout_d = mem_wdata[7:0];
                end else if (grant_if) begin
                    owner_d    = 1'b0;
                    addr_d     = if_addr;
                    n_d        = 3'd4;
                    cnt_d      = 3'd1;
                    rbuf_d     = '0;
                    ram_addr_d = if_addr;
                end
            end
            READ: begin
                if (if_abort) begin
                    cnt_d    = '0;
                    ram_wr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < n_q)
                        ram_addr_d = addr_k;
                    if (cnt_q >= 3'd2)
                        rbuf_d = rbuf_next;
                    if (cnt_q == n_q + 3'd1) begin
                        cnt_d = '0;
                        if (owner_q)
                            mem_rdata_d = rbuf_next;
                        else
                            if_data_d = rbuf_next;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == n_q) begin
                    cnt_d    = '0;
                    ram_wr_d = 1'b0;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_addr_d = addr_k;
                    ram_dout_d = wbyte;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if_done   = (state_q == DONE) & ~owner_q;
        mem_done  = (state_q == DONE) & owner_q;
        mem_stall = mem_req & ~mem_done;
        if_data   = if_data_q;
        mem_rdata = mem_rdata_q;
        ram_addr  = ram_addr_q;
        ram_wr    = ram_wr_q;
        ram_dout  = ram_dout_q;
    end

endmodule
